// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/writeback controller for a combinational 32-bit MIPS-subset ALU.
// One instruction at a time: IDLE -> DECODE -> EXEC -> WB, all outputs registered.
module alu_issue_ctrl #(
    parameter logic TRAP_EN     = 1'b1,
    parameter logic ILLEGAL_EXC = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_r,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        br_taken,
    output logic [31:0] br_offset,
    output logic        done,
    output logic        exc,
    output logic [1:0]  exc_code
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_WB     = 2'b11
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'd0, v};
    endfunction

    state_t      state_r, state_nxt;
    logic [31:0] instr_r, instr_nxt;

    // Instruction class captured at the end of DECODE
    logic [4:0]  dest_r, dest_nxt;
    logic        wr_r, wr_nxt;
    logic        beq_r, beq_nxt;
    logic        bne_r, bne_nxt;
    logic        ovchk_r, ovchk_nxt;
    logic [31:0] br_off_r, br_off_nxt;

    logic        instr_ready_r, instr_ready_nxt;
    logic [31:0] alu_a_r, alu_a_nxt;
    logic [31:0] alu_b_r, alu_b_nxt;
    logic [3:0]  alu_aluc_r, alu_aluc_nxt;
    logic        wb_en_r, wb_en_nxt;
    logic [4:0]  wb_addr_r, wb_addr_nxt;
    logic [31:0] wb_data_r, wb_data_nxt;
    logic        br_taken_r, br_taken_nxt;
    logic [31:0] br_offset_r, br_offset_nxt;
    logic        done_r, done_nxt;
    logic        exc_r, exc_nxt;
    logic [1:0]  exc_code_r, exc_code_nxt;

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [15:0] imm_s;
    logic [3:0]  dec_aluc_s;
    logic [31:0] dec_a_s;
    logic [31:0] dec_b_s;
    logic [4:0]  dec_dest_s;
    logic        dec_wr_s;
    logic        dec_beq_s;
    logic        dec_bne_s;
    logic        dec_ill_s;
    logic        ill_trap_s;
    logic        ov_trap_s;

    assign op_s    = instr_r[31:26];
    assign funct_s = instr_r[5:0];
    assign imm_s   = instr_r[15:0];

    // Instruction decode of the latched word: operands, aluc, destination, class
    always_comb begin
        dec_aluc_s = 4'b0000;
        dec_a_s    = rs_data;
        dec_b_s    = rt_data;
        dec_dest_s = instr_r[15:11];
        dec_wr_s   = 1'b0;
        dec_beq_s  = 1'b0;
        dec_bne_s  = 1'b0;
        dec_ill_s  = 1'b0;
        case (op_s)
            6'b000000: begin
                dec_wr_s = 1'b1;
                case (funct_s)
                    6'b100000: dec_aluc_s = 4'b0010;
                    6'b100001: dec_aluc_s = 4'b0000;
                    6'b100010: dec_aluc_s = 4'b0011;
                    6'b100011: dec_aluc_s = 4'b0001;
                    6'b100100: dec_aluc_s = 4'b0100;
                    6'b100101: dec_aluc_s = 4'b0101;
                    6'b100110: dec_aluc_s = 4'b0110;
                    6'b100111: dec_aluc_s = 4'b0111;
                    6'b101010: dec_aluc_s = 4'b1011;
                    6'b101011: dec_aluc_s = 4'b1010;
                    6'b000000: begin
                        dec_aluc_s = 4'b1110;
                        dec_a_s    = {27'd0, instr_r[10:6]};
                    end
                    6'b000010: begin
                        dec_aluc_s = 4'b1101;
                        dec_a_s    = {27'd0, instr_r[10:6]};
                    end
                    6'b000011: begin
                        dec_aluc_s = 4'b1100;
                        dec_a_s    = {27'd0, instr_r[10:6]};
                    end
                    6'b000100: dec_aluc_s = 4'b1110;
                    6'b000110: dec_aluc_s = 4'b1101;
                    6'b000111: dec_aluc_s = 4'b1100;
                    default: begin
                        dec_wr_s  = 1'b0;
                        dec_ill_s = 1'b1;
                    end
                endcase
            end
            6'b001000: begin dec_aluc_s = 4'b0010; dec_b_s = sext16(imm_s); dec_dest_s = instr_r[20:16]; dec_wr_s = 1'b1; end
            6'b001001: begin dec_aluc_s = 4'b0000; dec_b_s = sext16(imm_s); dec_dest_s = instr_r[20:16]; dec_wr_s = 1'b1; end
            6'b001010: begin dec_aluc_s = 4'b1011; dec_b_s = sext16(imm_s); dec_dest_s = instr_r[20:16]; dec_wr_s = 1'b1; end
            6'b001011: begin dec_aluc_s = 4'b1010; dec_b_s = sext16(imm_s); dec_dest_s = instr_r[20:16]; dec_wr_s = 1'b1; end
            6'b001100: begin dec_aluc_s = 4'b0100; dec_b_s = zext16(imm_s); dec_dest_s = instr_r[20:16]; dec_wr_s = 1'b1; end
            6'b001101: begin dec_aluc_s = 4'b0101; dec_b_s = zext16(imm_s); dec_dest_s = instr_r[20:16]; dec_wr_s = 1'b1; end
            6'b001110: begin dec_aluc_s = 4'b0110; dec_b_s = zext16(imm_s); dec_dest_s = instr_r[20:16]; dec_wr_s = 1'b1; end
            6'b001111: begin dec_aluc_s = 4'b1000; dec_b_s = zext16(imm_s); dec_dest_s = instr_r[20:16]; dec_wr_s = 1'b1; end
            6'b000100: begin dec_aluc_s = 4'b0001; dec_beq_s = 1'b1; end
            6'b000101: begin dec_aluc_s = 4'b0001; dec_bne_s = 1'b1; end
            default:   dec_ill_s = 1'b1;
        endcase
    end

    assign ill_trap_s = dec_ill_s & ILLEGAL_EXC;
    // The ALU overflow flag is only meaningful for the trapping add/sub opcodes
    assign ov_trap_s  = ovchk_r & alu_overflow & TRAP_EN;

    // Next-state logic and next values of every registered output
    always_comb begin
        state_nxt       = state_r;
        instr_nxt       = instr_r;
        dest_nxt        = dest_r;
        wr_nxt          = wr_r;
        beq_nxt         = beq_r;
        bne_nxt         = bne_r;
        ovchk_nxt       = ovchk_r;
        br_off_nxt      = br_off_r;
        alu_a_nxt       = 32'd0;
        alu_b_nxt       = 32'd0;
        alu_aluc_nxt    = 4'b0000;
        wb_en_nxt       = 1'b0;
        wb_addr_nxt     = 5'd0;
        wb_data_nxt     = 32'd0;
        br_taken_nxt    = 1'b0;
        br_offset_nxt   = 32'd0;
        done_nxt        = 1'b0;
        exc_nxt         = 1'b0;
        exc_code_nxt    = exc_code_r;
        case (state_r)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_nxt = instr;
                    state_nxt = S_DECODE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_DECODE: begin
                dest_nxt   = dec_dest_s;
                wr_nxt     = dec_wr_s;
                beq_nxt    = dec_beq_s;
                bne_nxt    = dec_bne_s;
                ovchk_nxt  = (dec_aluc_s == 4'b0010) || (dec_aluc_s == 4'b0011);
                br_off_nxt = {{14{imm_s[15]}}, imm_s, 2'b00};
                if (ill_trap_s) begin
                    state_nxt    = S_WB;
                    done_nxt     = 1'b1;
                    exc_nxt      = 1'b1;
                    exc_code_nxt = 2'b10;
                end else begin
                    state_nxt    = S_EXEC;
                    alu_a_nxt    = dec_a_s;
                    alu_b_nxt    = dec_b_s;
                    alu_aluc_nxt = dec_aluc_s;
                end
            end
            S_EXEC: begin
                state_nxt    = S_WB;
                done_nxt     = 1'b1;
                wb_addr_nxt  = dest_r;
                wb_data_nxt  = alu_r;
                br_taken_nxt = (beq_r & alu_zero) | (bne_r & ~alu_zero);
                if (beq_r || bne_r) begin
                    br_offset_nxt = br_off_r;
                end else begin
                    br_offset_nxt = 32'd0;
                end
                if (ov_trap_s) begin
                    exc_nxt      = 1'b1;
                    exc_code_nxt = 2'b01;
                end else begin
                    exc_code_nxt = 2'b00;
                    wb_en_nxt    = wr_r && (dest_r != 5'd0);
                end
            end
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        instr_ready_nxt = (state_nxt == S_IDLE);
    end

    // State, class and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            instr_r       <= 32'd0;
            dest_r        <= 5'd0;
            wr_r          <= 1'b0;
            beq_r         <= 1'b0;
            bne_r         <= 1'b0;
            ovchk_r       <= 1'b0;
            br_off_r      <= 32'd0;
            instr_ready_r <= 1'b1;
            alu_a_r       <= 32'd0;
            alu_b_r       <= 32'd0;
            alu_aluc_r    <= 4'b0000;
            wb_en_r       <= 1'b0;
            wb_addr_r     <= 5'd0;
            wb_data_r     <= 32'd0;
            br_taken_r    <= 1'b0;
            br_offset_r   <= 32'd0;
            done_r        <= 1'b0;
            exc_r         <= 1'b0;
            exc_code_r    <= 2'b00;
        end else begin
            state_r       <= state_nxt;
            instr_r       <= instr_nxt;
            dest_r        <= dest_nxt;
            wr_r          <= wr_nxt;
            beq_r         <= beq_nxt;
            bne_r         <= bne_nxt;
            ovchk_r       <= ovchk_nxt;
            br_off_r      <= br_off_nxt;
            instr_ready_r <= instr_ready_nxt;
            alu_a_r       <= alu_a_nxt;
            alu_b_r       <= alu_b_nxt;
            alu_aluc_r    <= alu_aluc_nxt;
            wb_en_r       <= wb_en_nxt;
            wb_addr_r     <= wb_addr_nxt;
            wb_data_r     <= wb_data_nxt;
            br_taken_r    <= br_taken_nxt;
            br_offset_r   <= br_offset_nxt;
            done_r        <= done_nxt;
            exc_r         <= exc_nxt;
            exc_code_r    <= exc_code_nxt;
        end
    end

    assign instr_ready = instr_ready_r;
    assign rs_addr     = instr_r[25:21];
    assign rt_addr     = instr_r[20:16];
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_aluc    = alu_aluc_r;
    assign wb_en       = wb_en_r;
    assign wb_addr     = wb_addr_r;
    assign wb_data     = wb_data_r;
    assign br_taken    = br_taken_r;
    assign br_offset   = br_offset_r;
    assign done        = done_r;
    assign exc         = exc_r;
    assign exc_code    = exc_code_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU and register file, a vector table driven through
// two instances (traps on / traps off) and per-instance scoreboards checked at retire.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] regs [32];

    logic        instr_ready, instr_ready2;
    logic [4:0]  rs_addr, rt_addr, rs_addr2, rt_addr2;
    logic [31:0] rs_data, rt_data, rs_data2, rt_data2;
    logic [31:0] alu_a, alu_b, alu_a2, alu_b2;
    logic [3:0]  alu_aluc, alu_aluc2;
    logic [31:0] alu_r, alu_r2;
    logic        alu_zero, alu_zero2, alu_overflow, alu_overflow2;
    logic        wb_en, wb_en2;
    logic [4:0]  wb_addr, wb_addr2;
    logic [31:0] wb_data, wb_data2;
    logic        br_taken, br_taken2;
    logic [31:0] br_offset, br_offset2;
    logic        done, done2, exc, exc2;
    logic [1:0]  exc_code, exc_code2;

    // Environment ALU; it also flags signed overflow on addu/subu, which the controller must ignore
    function automatic logic [33:0] alu_m(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        logic [31:0] r;
        logic        ov;
        r  = 32'd0;
        ov = 1'b0;
        case (c)
            4'b0000: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0010: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); if (ov) r = 32'd0; end
            4'b0001: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b0011: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); if (ov) r = 32'd0; end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~(a | b);
            4'b1000, 4'b1001: r = {b[15:0], 16'd0};
            4'b1011: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1010: r = (a < b) ? 32'd1 : 32'd0;
            4'b1100: r = $signed(b) >>> a[4:0];
            4'b1101: r = b >> a[4:0];
            default: r = b << a[4:0];
        endcase
        return {ov, (r == 32'd0), r};
    endfunction

    assign rs_data  = regs[rs_addr];
    assign rt_data  = regs[rt_addr];
    assign rs_data2 = regs[rs_addr2];
    assign rt_data2 = regs[rt_addr2];
    assign {alu_overflow, alu_zero, alu_r}    = alu_m(alu_a, alu_b, alu_aluc);
    assign {alu_overflow2, alu_zero2, alu_r2} = alu_m(alu_a2, alu_b2, alu_aluc2);

    alu_issue_ctrl #(.TRAP_EN(1'b1), .ILLEGAL_EXC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .br_taken(br_taken), .br_offset(br_offset), .done(done), .exc(exc), .exc_code(exc_code)
    );

    alu_issue_ctrl #(.TRAP_EN(1'b0), .ILLEGAL_EXC(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready2), .instr(instr),
        .rs_addr(rs_addr2), .rt_addr(rt_addr2), .rs_data(rs_data2), .rt_data(rt_data2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_aluc(alu_aluc2), .alu_r(alu_r2), .alu_zero(alu_zero2),
        .alu_overflow(alu_overflow2), .wb_en(wb_en2), .wb_addr(wb_addr2), .wb_data(wb_data2),
        .br_taken(br_taken2), .br_offset(br_offset2), .done(done2), .exc(exc2), .exc_code(exc_code2)
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [3:0]  aluc;
        logic [31:0] a;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        br;
        logic [31:0] boff;
        logic        ex;
        logic [1:0]  code;
        int          lat;
        logic        ov;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        br;
        logic        isbr;
        logic [31:0] boff;
        logic        ex;
        logic [1:0]  code;
        int          due;
    } exp_t;

    localparam int NV = 19;
    vec_t vecs [NV];
    exp_t q1 [$];
    exp_t q2 [$];
    exp_t m1, m2;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   acc0, acc1, nacc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] r_enc(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_enc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv,
                                input logic [3:0] aluc, input logic [31:0] a, input logic wen,
                                input logic [4:0] waddr, input logic [31:0] wdata, input logic br,
                                input logic [31:0] boff, input logic ex, input logic [1:0] code,
                                input int lat, input logic ov, input logic ill);
        vec_t v;
        v.ins = ins; v.rsv = rsv; v.rtv = rtv; v.aluc = aluc; v.a = a; v.wen = wen; v.waddr = waddr;
        v.wdata = wdata; v.br = br; v.boff = boff; v.ex = ex; v.code = code; v.lat = lat; v.ov = ov; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic wen, input logic [4:0] wa,
                       input logic [31:0] wd, input logic br, input logic [31:0] bo, input logic ex,
                       input logic [1:0] ec);
        chk({tag, ".wb_en"}, 32'(wen), 32'(e.wen));
        if (e.wen) begin
            chk({tag, ".wb_addr"}, 32'(wa), 32'(e.waddr));
            chk({tag, ".wb_data"}, wd, e.wdata);
        end
        chk({tag, ".br_taken"}, 32'(br), 32'(e.br));
        if (e.isbr) chk({tag, ".br_offset"}, bo, e.boff);
        chk({tag, ".exc"}, 32'(ex), 32'(e.ex));
        chk({tag, ".exc_code"}, 32'(ec), 32'(e.code));
        chk({tag, ".latency"}, 32'(cyc), 32'(e.due));
    endtask

    // Retire monitor for the trapping instance
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL dut1.spurious_done: got done=1 expected no retire");
            end else begin
                m1 = q1.pop_front();
                cmp("dut1", m1, wb_en, wb_addr, wb_data, br_taken, br_offset, exc, exc_code);
            end
        end
    end

    // Retire monitor for the non-trapping instance
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL dut2.spurious_done: got done=1 expected no retire");
            end else begin
                m2 = q2.pop_front();
                cmp("dut2", m2, wb_en2, wb_addr2, wb_data2, br_taken2, br_offset2, exc2, exc_code2);
            end
        end
    end

    task automatic push(input int i);
        exp_t e, e2;
        e.wen   = vecs[i].wen;
        e.waddr = vecs[i].waddr;
        e.wdata = vecs[i].wdata;
        e.br    = vecs[i].br;
        e.isbr  = (vecs[i].ins[31:26] == 6'b000100) || (vecs[i].ins[31:26] == 6'b000101);
        e.boff  = vecs[i].boff;
        e.ex    = vecs[i].ex;
        e.code  = vecs[i].code;
        e.due   = cyc + vecs[i].lat;
        q1.push_back(e);
        e2      = e;
        e2.ex   = 1'b0;
        e2.code = 2'b00;
        if (vecs[i].ill) e2.due = cyc + 3;
        if (vecs[i].ov) begin
            e2.wen   = (vecs[i].waddr != 5'd0);
            e2.wdata = 32'd0;
        end
        q2.push_back(e2);
    endtask

    task automatic load_regs(input int i);
        logic [31:0] w;
        w = vecs[i].ins;
        regs[w[25:21]] = vecs[i].rsv;
        regs[w[20:16]] = vecs[i].rtv;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!(instr_ready === 1'b1 && instr_ready2 === 1'b1) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("idle_wait_timeout", 32'(w >= 20), 32'd0);
    endtask

    task automatic issue(input int i);
        wait_idle();
        load_regs(i);
        instr       = vecs[i].ins;
        instr_valid = 1'b1;
        push(i);
        @(negedge clk);
        instr_valid = 1'b0;
        chk($sformatf("decode_aluc_zero[%0d]", i), 32'(alu_aluc), 32'd0);
        chk($sformatf("busy_not_ready[%0d]", i), 32'(instr_ready), 32'd0);
        @(negedge clk);
        if (!vecs[i].ill) begin
            chk($sformatf("exec_aluc[%0d]", i), 32'(alu_aluc), 32'(vecs[i].aluc));
            chk($sformatf("exec_a[%0d]", i), alu_a, vecs[i].a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(r_enc(5'd5, 5'd6, 5'd3, 5'd0, 6'h21), 32'h7, 32'h9, 4'b0000, 32'h7, 1'b1, 5'd3, 32'h10, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[1]  = mk(r_enc(5'd5, 5'd6, 5'd3, 5'd0, 6'h20), 32'h7FFFFFFF, 32'h1, 4'b0010, 32'h7FFFFFFF, 1'b0, 5'd3, 32'h0, 1'b0, 32'h0, 1'b1, 2'b01, 3, 1'b1, 1'b0);
        vecs[2]  = mk(r_enc(5'd0, 5'd4, 5'd2, 5'd4, 6'h03), 32'h0, 32'hF0000000, 4'b1100, 32'h4, 1'b1, 5'd2, 32'hFF000000, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[3]  = mk(i_enc(6'h0F, 5'd0, 5'd1, 16'h1234), 32'h0, 32'h0, 4'b1000, 32'h0, 1'b1, 5'd1, 32'h12340000, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[4]  = mk(i_enc(6'h04, 5'd5, 5'd6, 16'hFFFF), 32'hAB, 32'hAB, 4'b0001, 32'hAB, 1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFFFFFC, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[5]  = mk(i_enc(6'h05, 5'd5, 5'd6, 16'hFFFF), 32'hAB, 32'hAB, 4'b0001, 32'hAB, 1'b0, 5'd0, 32'h0, 1'b0, 32'hFFFFFFFC, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[6]  = mk(32'hFC000000, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b10, 2, 1'b0, 1'b1);
        vecs[7]  = mk(r_enc(5'd5, 5'd6, 5'd0, 5'd0, 6'h21), 32'h7, 32'h9, 4'b0000, 32'h7, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[8]  = mk(r_enc(5'd5, 5'd6, 5'd3, 5'd0, 6'h22), 32'h5, 32'h9, 4'b0011, 32'h5, 1'b1, 5'd3, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[9]  = mk(r_enc(5'd5, 5'd6, 5'd4, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'h1, 4'b1011, 32'hFFFFFFFF, 1'b1, 5'd4, 32'h1, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[10] = mk(r_enc(5'd5, 5'd6, 5'd4, 5'd0, 6'h2B), 32'hFFFFFFFF, 32'h1, 4'b1010, 32'hFFFFFFFF, 1'b1, 5'd4, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[11] = mk(i_enc(6'h08, 5'd5, 5'd7, 16'hFFFE), 32'd10, 32'h0, 4'b0010, 32'd10, 1'b1, 5'd7, 32'd8, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[12] = mk(i_enc(6'h0C, 5'd5, 5'd7, 16'hFFF0), 32'h1234ABCD, 32'h0, 4'b0100, 32'h1234ABCD, 1'b1, 5'd7, 32'h0000ABC0, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[13] = mk(r_enc(5'd9, 5'd10, 5'd8, 5'd0, 6'h04), 32'h4, 32'hF, 4'b1110, 32'h4, 1'b1, 5'd8, 32'hF0, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[14] = mk(r_enc(5'd5, 5'd6, 5'd3, 5'd0, 6'h27), 32'h0F0F0F0F, 32'hF0F00000, 4'b0111, 32'h0F0F0F0F, 1'b1, 5'd3, 32'h0000F0F0, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[15] = mk(r_enc(5'd5, 5'd6, 5'd3, 5'd0, 6'h22), 32'h80000000, 32'h1, 4'b0011, 32'h80000000, 1'b0, 5'd3, 32'h0, 1'b0, 32'h0, 1'b1, 2'b01, 3, 1'b1, 1'b0);
        vecs[16] = mk(i_enc(6'h0E, 5'd5, 5'd7, 16'h00FF), 32'hFFFF0000, 32'h0, 4'b0110, 32'hFFFF0000, 1'b1, 5'd7, 32'hFFFF00FF, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[17] = mk(r_enc(5'd0, 5'd4, 5'd2, 5'd8, 6'h02), 32'h0, 32'h80000000, 4'b1101, 32'h8, 1'b1, 5'd2, 32'h00800000, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);
        vecs[18] = mk(r_enc(5'd5, 5'd6, 5'd3, 5'd0, 6'h21), 32'h7FFFFFFF, 32'h1, 4'b0000, 32'h7FFFFFFF, 1'b1, 5'd3, 32'h80000000, 1'b0, 32'h0, 1'b0, 2'b00, 3, 1'b0, 1'b0);

        for (int r = 0; r < 32; r++) regs[r] = 32'd0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.instr_ready", 32'(instr_ready), 32'd1);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.wb_en", 32'(wb_en), 32'd0);
        chk("reset.exc", 32'(exc), 32'd0);
        chk("reset.exc_code", 32'(exc_code), 32'd0);
        chk("reset.alu_aluc", 32'(alu_aluc), 32'd0);
        chk("reset.rs_addr", 32'(rs_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            issue(i);
            if (vecs[i].ex) begin
                repeat (2) @(negedge clk);
                chk($sformatf("exc_code_held[%0d]", i), 32'(exc_code), 32'(vecs[i].code));
                chk($sformatf("done_single_cycle[%0d]", i), 32'(done), 32'd0);
            end
        end

        // Reset while the instruction sits in EXEC: aborted with no retire strobes
        wait_idle();
        load_regs(8);
        instr       = vecs[8].ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort.exec_aluc", 32'(alu_aluc), 32'(4'b0011));
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.instr_ready", 32'(instr_ready), 32'd1);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.wb_en", 32'(wb_en), 32'd0);
        chk("abort.exc", 32'(exc), 32'd0);
        chk("abort.alu_aluc", 32'(alu_aluc), 32'd0);
        chk("abort.alu_a", alu_a, 32'd0);
        chk("abort.br_taken", 32'(br_taken), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort.idle_after", 32'(instr_ready), 32'd1);

        // Back-to-back offers with instr_valid held high
        wait_idle();
        load_regs(2);
        load_regs(13);
        nacc        = 0;
        instr       = vecs[2].ins;
        instr_valid = 1'b1;
        for (int t = 0; t < 24 && nacc < 2; t++) begin
            if (instr_ready === 1'b1 && instr_ready2 === 1'b1) begin
                if (nacc == 0) begin acc0 = cyc; push(2); end
                else begin acc1 = cyc; push(13); end
                nacc++;
            end
            @(negedge clk);
            if (nacc == 1) instr = vecs[13].ins;
        end
        instr_valid = 1'b0;
        chk("b2b.accepts", 32'(nacc), 32'd2);
        chk("b2b.spacing", 32'(acc1 - acc0), 32'd4);

        repeat (8) @(negedge clk);
        chk("drain.q1_empty", 32'(q1.size()), 32'd0);
        chk("drain.q2_empty", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
